// File: rtl/prog_mem.sv
// prog_mem: program store. Clears itself to NOP after reset, then serves one-cycle fetches and single-word loads, with a sticky write lock.
// Ports: clk, rst_n (sync, low), fetch_req/fetch_addr/fetch_ready, instr/instr_valid, load_en/load_addr/load_data, lock, busy, addr_err. Option macro: PROG_MEM_PARITY_EN.
module prog_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 35,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              lock,
  output logic              busy,
  output logic              addr_err
);

`ifdef PROG_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_lock;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_addr_err;
  logic [MEM_W-1:0]  r_mem [DEPTH];

  logic              w_f_in;
  logic              w_l_in;
  logic              w_last;
  logic              w_busy;
  logic              w_fetch_ready;
  logic              w_fetch_acc;
  logic              w_load_acc;
  logic              w_load_drop;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [MEM_W-1:0]  w_wdata;
  logic [MEM_W-1:0]  w_rd_word;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_perr;

  assign w_f_in = 32'(fetch_addr) < DEPTH_U;
  assign w_l_in = 32'(load_addr) < DEPTH_U;
  assign w_last = 32'(r_ptr) == (DEPTH_U - 32'd1);

  assign w_rd_word = w_f_in ? r_mem[fetch_addr] : '0;

`ifdef PROG_MEM_PARITY_EN
  assign w_rd_data = w_rd_word[DATA_W-1:0];
  // stored word carries even parity across all bits
  assign w_perr    = ^w_rd_word;
`else
  assign w_rd_data = w_rd_word;
  assign w_perr    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_busy        = 1'b0;
    w_fetch_ready = 1'b0;
    w_load_acc    = 1'b0;
    w_load_drop   = 1'b0;
    w_we          = 1'b0;
    w_waddr       = r_ptr;
    w_wdata       = '0;
    unique case (r_state)
      S_CLEAR: begin
        w_busy    = 1'b1;
        w_we      = 1'b1;
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (w_last) begin
          w_state_nxt = S_RUN;
          w_ptr_nxt   = '0;
        end
      end
      S_RUN: begin
        w_load_acc    = load_en & ~r_lock;
        w_load_drop   = load_en & r_lock;
        // a load owns the array this cycle
        w_fetch_ready = ~w_load_acc;
        w_we          = w_load_acc & w_l_in;
        w_waddr       = load_addr;
`ifdef PROG_MEM_PARITY_EN
        w_wdata       = {^load_data, load_data};
`else
        w_wdata       = load_data;
`endif
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign w_fetch_acc = fetch_req & w_fetch_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_lock  <= r_lock | lock;
      r_valid <= w_fetch_acc;
      if (w_fetch_acc) begin
        r_instr <= (w_f_in & ~w_perr) ? w_rd_data : '0;
      end
      r_addr_err <= (w_fetch_acc & (~w_f_in | w_perr))
                  | w_load_drop
                  | (w_load_acc & ~w_l_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign fetch_ready = w_fetch_ready;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign busy        = w_busy;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed checks of prog_mem, default build plus a DEPTH=200 instance.
// Ports: none; drives clk/rst_n and both DUT port sets.
module tb_prog_mem;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        f_req;
  logic [7:0]  f_addr;
  logic        f_rdy;
  logic [34:0] ins;
  logic        ins_v;
  logic        l_en;
  logic [7:0]  l_addr;
  logic [34:0] l_data;
  logic        lk;
  logic        bsy;
  logic        aerr;

  logic        f2_req;
  logic [7:0]  f2_addr;
  logic        f2_rdy;
  logic [34:0] ins2;
  logic        ins2_v;
  logic        l2_en;
  logic [7:0]  l2_addr;
  logic [34:0] l2_data;
  logic        lk2;
  logic        bsy2;
  logic        aerr2;

  int n_pass = 0;
  int n_tot  = 0;
  int n;
  int n2;

  localparam logic [34:0] D1 = 35'h1_2345_6789;
  localparam logic [34:0] D2 = 35'h2_AAAA_5555;
  localparam logic [34:0] D3 = 35'h7_0F0F_00F1;
  localparam logic [34:0] D4 = 35'h0_0000_00AB;

  always #5 clk = ~clk;

  prog_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (f_req),
    .fetch_addr  (f_addr),
    .fetch_ready (f_rdy),
    .instr       (ins),
    .instr_valid (ins_v),
    .load_en     (l_en),
    .load_addr   (l_addr),
    .load_data   (l_data),
    .lock        (lk),
    .busy        (bsy),
    .addr_err    (aerr)
  );

  prog_mem #(.DEPTH(200)) dut200 (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (f2_req),
    .fetch_addr  (f2_addr),
    .fetch_ready (f2_rdy),
    .instr       (ins2),
    .instr_valid (ins2_v),
    .load_en     (l2_en),
    .load_addr   (l2_addr),
    .load_data   (l2_data),
    .lock        (lk2),
    .busy        (bsy2),
    .addr_err    (aerr2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; f_addr = '0; l_en = 1'b0; l_addr = '0;
    l_data = '0; lk = 1'b0;
    f2_req = 1'b0; f2_addr = '0; l2_en = 1'b0; l2_addr = '0;
    l2_data = '0; lk2 = 1'b0;

    cyc();
    chk("rst_ready", 64'(f_rdy), 64'd0);
    chk("rst_instr", 64'(ins), 64'd0);
    chk("rst_valid", 64'(ins_v), 64'd0);
    chk("rst_busy", 64'(bsy), 64'd1);
    chk("rst_aerr", 64'(aerr), 64'd0);
    rst_n = 1'b1;

    n = 0;
    n2 = 0;
    while (bsy === 1'b1 && n < 400) begin
      n++;
      if (bsy2 === 1'b1) n2++;
      cyc();
    end
    chk("sweep_len", 64'(n), 64'd256);
    chk("sweep200_len", 64'(n2), 64'd200);

    f_req = 1'b1; f_addr = 8'd17;
    #1 chk("run_ready", 64'(f_rdy), 64'd1);
    cyc();
    f_req = 1'b0;
    chk("f17_valid", 64'(ins_v), 64'd1);
    chk("f17_instr", 64'(ins), 64'd0);
    chk("f17_aerr", 64'(aerr), 64'd0);
    cyc();
    chk("f17_vdrop", 64'(ins_v), 64'd0);

    l_en = 1'b1; l_addr = 8'd4; l_data = D1;
    #1 chk("ld4_ready", 64'(f_rdy), 64'd0);
    cyc();
    l_en = 1'b0;
    f_req = 1'b1; f_addr = 8'd4;
    cyc();
    f_req = 1'b0;
    chk("f4_valid", 64'(ins_v), 64'd1);
    chk("f4_instr", 64'(ins), 64'(D1));
    cyc();
    chk("f4_hold", 64'(ins), 64'(D1));

    l_en = 1'b1; l_addr = 8'd8; l_data = D2;
    f_req = 1'b1; f_addr = 8'd8;
    #1 chk("col_ready", 64'(f_rdy), 64'd0);
    cyc();
    l_en = 1'b0;
    chk("col_novalid", 64'(ins_v), 64'd0);
    #1 chk("col_ready2", 64'(f_rdy), 64'd1);
    cyc();
    f_req = 1'b0;
    chk("col_valid", 64'(ins_v), 64'd1);
    chk("col_instr", 64'(ins), 64'(D2));

    lk = 1'b1;
    cyc();
    lk = 1'b0;
    l_en = 1'b1; l_addr = 8'd4; l_data = '0;
    #1 chk("lk_ready", 64'(f_rdy), 64'd1);
    cyc();
    l_en = 1'b0;
    chk("lk_aerr", 64'(aerr), 64'd1);
    f_req = 1'b1; f_addr = 8'd4;
    cyc();
    f_req = 1'b0;
    chk("lk_instr", 64'(ins), 64'(D1));
    chk("lk_aerr_end", 64'(aerr), 64'd0);

    l2_en = 1'b1; l2_addr = 8'd199; l2_data = D3;
    cyc();
    l2_en = 1'b0;
    chk("d2_ld199_aerr", 64'(aerr2), 64'd0);
    f2_req = 1'b1; f2_addr = 8'd199;
    cyc();
    f2_req = 1'b0;
    chk("d2_f199_instr", 64'(ins2), 64'(D3));
    chk("d2_f199_aerr", 64'(aerr2), 64'd0);
    l2_en = 1'b1; l2_addr = 8'd250; l2_data = D4;
    cyc();
    l2_en = 1'b0;
    chk("d2_ld250_aerr", 64'(aerr2), 64'd1);
    f2_req = 1'b1; f2_addr = 8'd210;
    cyc();
    f2_req = 1'b0;
    chk("d2_f210_valid", 64'(ins2_v), 64'd1);
    chk("d2_f210_instr", 64'(ins2), 64'd0);
    chk("d2_f210_aerr", 64'(aerr2), 64'd1);
    cyc();
    chk("d2_aerr_pulse", 64'(aerr2), 64'd0);

    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (100) cyc();
    chk("mid_busy", 64'(bsy), 64'd1);
    f_req = 1'b1; f_addr = 8'd4;
    #1 chk("mid_ready", 64'(f_rdy), 64'd0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    f_req = 1'b0;
    chk("rst2_busy", 64'(bsy), 64'd1);
    chk("rst2_valid", 64'(ins_v), 64'd0);
    n = 0;
    while (bsy === 1'b1 && n < 400) begin
      n++;
      cyc();
    end
    chk("sweep2_len", 64'(n), 64'd256);

    f_req = 1'b1; f_addr = 8'd4;
    cyc();
    chk("clr4_instr", 64'(ins), 64'd0);
    chk("clr4_valid", 64'(ins_v), 64'd1);
    f_addr = 8'd8;
    cyc();
    f_req = 1'b0;
    chk("clr8_instr", 64'(ins), 64'd0);

    l_en = 1'b1; l_addr = 8'd4; l_data = D4;
    cyc();
    l_en = 1'b0;
    chk("unlk_aerr", 64'(aerr), 64'd0);
    f_req = 1'b1; f_addr = 8'd4;
    cyc();
    f_req = 1'b0;
    chk("unlk_instr", 64'(ins), 64'(D4));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
